// File: rtl/hdmi_pix_unpack.sv
// HDMI read-side width converter: unpacks IW-bit FWFT FIFO words into OW-bit pixels.
// Optional HDMI_PIX_UNPACK_LINE_ALIGN_EN restarts every line on a fresh FIFO word.
module hdmi_pix_unpack #(
  parameter int unsigned IW        = 256,
  parameter int unsigned OW        = 16,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned VS_POL    = 1
) (
  input  logic          hdmi_clk,
  input  logic          rst_n,
  input  logic          hdmi_pre_de,
  input  logic          hdmi_pre_hsync,
  input  logic          hdmi_pre_vsync,
  output logic          hdmi_post_de,
  output logic          hdmi_post_hsync,
  output logic          hdmi_post_vsync,
  output logic [OW-1:0] hdmi_pix,
  output logic          fifo_rd_en,
  input  logic [IW-1:0] fifo_rd_data,
  input  logic          fifo_empty,
  output logic          underflow,
  output logic [15:0]   underflow_cnt
);

  localparam int unsigned N      = IW / OW;
  localparam int unsigned CW     = $clog2(N);
  localparam logic        VS_ACT = (VS_POL != 0);
  localparam logic        MSB    = (MSB_FIRST != 0);

  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic [IW-1:0] sreg_q, sreg_d;
  logic          vs_prev_q;
  logic          de_q, hs_q, vs_q;
  logic          underflow_q, underflow_d;
  logic [15:0]   ucnt_q, ucnt_d;
  logic          vs_edge, need;
  logic [OW-1:0] slice;

  // Slice counter, shift register and underflow bookkeeping
  always_comb begin
    vs_edge     = (hdmi_pre_vsync == VS_ACT) && (vs_prev_q != VS_ACT);
    cnt_eff     = vs_edge ? '0 : cnt_q;
    need        = hdmi_pre_de && (cnt_eff == '0);
    fifo_rd_en  = need && !fifo_empty;
    cnt_d       = cnt_eff;
    sreg_d      = sreg_q;
    underflow_d = 1'b0;
    ucnt_d      = ucnt_q;

    if (hdmi_pre_de) begin
      if (need) begin
        sreg_d = fifo_empty ? '0 : fifo_rd_data;
      end else begin
        sreg_d = MSB ? (sreg_q << OW) : (sreg_q >> OW);
      end
      cnt_d = (cnt_eff == CW'(N - 1)) ? '0 : cnt_eff + CW'(1);
    end

`ifdef HDMI_PIX_UNPACK_LINE_ALIGN_EN
    // End of line drops the rest of the current word
    if (!hdmi_pre_de && de_q) begin
      cnt_d = '0;
    end
`endif

    if (need && fifo_empty) begin
      underflow_d = 1'b1;
      if (ucnt_q != 16'hFFFF) begin
        ucnt_d = ucnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sreg_q      <= '0;
      vs_prev_q   <= ~VS_ACT;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      underflow_q <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      vs_prev_q   <= hdmi_pre_vsync;
      de_q        <= hdmi_pre_de;
      hs_q        <= hdmi_pre_hsync;
      vs_q        <= hdmi_pre_vsync;
      underflow_q <= underflow_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign slice           = MSB ? sreg_q[IW-1 -: OW] : sreg_q[OW-1:0];
  assign hdmi_pix        = de_q ? slice : '0;
  assign hdmi_post_de    = de_q;
  assign hdmi_post_hsync = hs_q;
  assign hdmi_post_vsync = vs_q;
  assign underflow       = underflow_q;
  assign underflow_cnt   = ucnt_q;

endmodule

// File: tb/tb_hdmi_pix_unpack.sv
// Directed bench for hdmi_pix_unpack: MSB-first and LSB-first instances share one FIFO model.
module tb_hdmi_pix_unpack;

  logic         hdmi_clk;
  logic         rst_n;
  logic         pre_de, pre_hs, pre_vs;
  logic [255:0] fifo_rd_data;
  logic         fifo_empty;

  logic         post_de_m, hs_m, vs_m, rd_m, uf_m;
  logic [15:0]  pix_m, ucnt_m;
  logic         post_de_l, hs_l, vs_l, rd_l, uf_l;
  logic [15:0]  pix_l, ucnt_l;

  logic [255:0] fq[$];
  logic         rd0, rd1;
  int           total, bad;

  hdmi_pix_unpack u_msb (
    .hdmi_clk(hdmi_clk), .rst_n(rst_n),
    .hdmi_pre_de(pre_de), .hdmi_pre_hsync(pre_hs), .hdmi_pre_vsync(pre_vs),
    .hdmi_post_de(post_de_m), .hdmi_post_hsync(hs_m), .hdmi_post_vsync(vs_m),
    .hdmi_pix(pix_m), .fifo_rd_en(rd_m), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .underflow(uf_m), .underflow_cnt(ucnt_m)
  );

  hdmi_pix_unpack #(.MSB_FIRST(0)) u_lsb (
    .hdmi_clk(hdmi_clk), .rst_n(rst_n),
    .hdmi_pre_de(pre_de), .hdmi_pre_hsync(pre_hs), .hdmi_pre_vsync(pre_vs),
    .hdmi_post_de(post_de_l), .hdmi_post_hsync(hs_l), .hdmi_post_vsync(vs_l),
    .hdmi_pix(pix_l), .fifo_rd_en(rd_l), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .underflow(uf_l), .underflow_cnt(ucnt_l)
  );

  initial hdmi_clk = 1'b0;
  always #5 hdmi_clk = ~hdmi_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Word k holds 16'(k<<8 | j) in slice j (bits [16j+15:16j])
  function automatic logic [255:0] mk_word(input int k);
    logic [255:0] w;
    for (int j = 0; j < 16; j++) w[16*j +: 16] = 16'((k << 8) | j);
    return w;
  endfunction

  // Drive one cycle at the negedge, capture rd_en, pop on the clock, return at next negedge
  task automatic step(input logic de, input logic hs, input logic vs);
    pre_de = de;
    pre_hs = hs;
    pre_vs = vs;
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = fifo_empty ? {8{32'hDEAD_BEEF}} : fq[0];
    #1;
    rd0 = rd_m;
    rd1 = rd_l;
    @(posedge hdmi_clk);
    if (rd0) void'(fq.pop_front());
    @(negedge hdmi_clk);
  endtask

  task automatic rd_chk(input string tag, input logic exp);
    check({tag, "_rdm"}, 32'(rd0), 32'(exp));
    check({tag, "_rdl"}, 32'(rd1), 32'(exp));
  endtask

  // k < 0 means a zero-filled (underflow) word
  task automatic pix_chk(input string tag, input int k, input int j);
    logic [15:0] em, el;
    if (k < 0) begin
      em = 16'h0;
      el = 16'h0;
    end else begin
      em = 16'((k << 8) | (15 - j));
      el = 16'((k << 8) | j);
    end
    check({tag, "_de"}, 32'(post_de_m), 32'd1);
    check({tag, "_del"}, 32'(post_de_l), 32'd1);
    check({tag, "_pm"}, 32'(pix_m), 32'(em));
    check({tag, "_pl"}, 32'(pix_l), 32'(el));
  endtask

  task automatic idle_chk(input string tag);
    check({tag, "_de"}, 32'(post_de_m), 32'd0);
    check({tag, "_pm"}, 32'(pix_m), 32'd0);
    check({tag, "_pl"}, 32'(pix_l), 32'd0);
  endtask

  task automatic run_word(input string tag, input int k);
    for (int j = 0; j < 16; j++) begin
      step(1'b1, 1'b0, 1'b0);
      rd_chk(tag, j == 0);
      pix_chk(tag, k, j);
    end
  endtask

  initial begin
    int k, j;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    pre_de = 1'b0;
    pre_hs = 1'b0;
    pre_vs = 1'b0;
    fifo_empty = 1'b1;
    fifo_rd_data = '0;
    @(negedge hdmi_clk);

    // Reset state
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    idle_chk("rst");
    check("rst_hs", 32'(hs_m), 32'd0);
    check("rst_vs", 32'(vs_m), 32'd0);
    check("rst_uf", 32'(uf_m), 32'd0);
    check("rst_ucnt", 32'(ucnt_m), 32'd0);
    check("rst_ucntl", 32'(ucnt_l), 32'd0);
    rst_n = 1'b1;

    // hsync/vsync one-cycle delay
    step(1'b0, 1'b1, 1'b0);
    check("hs_dly", 32'(hs_m), 32'd1);
    check("hs_dlyl", 32'(hs_l), 32'd1);
    check("vs_lo", 32'(vs_m), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("hs_lo", 32'(hs_m), 32'd0);
    check("vs_dly", 32'(vs_m), 32'd1);
    check("vs_dlyl", 32'(vs_l), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    idle_chk("pre");

    // Continuous de over three words
    for (int i = 0; i < 3; i++) fq.push_back(mk_word(i));
    for (int i = 0; i < 3; i++) run_word("cont", i);
    check("cont_fq", 32'(fq.size()), 32'd0);
    check("cont_uf", 32'(ucnt_m), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    idle_chk("cont_end");

    // de gap mid-word: 5 on, 3 off, 11 on
    fq.push_back(mk_word(3));
    fq.push_back(mk_word(15));
    k = 3;
    j = 0;
    for (int i = 0; i < 19; i++) begin
      if (i < 5 || i >= 8) begin
        step(1'b1, 1'b0, 1'b0);
        rd_chk("gap", j == 0);
        pix_chk("gap", k, j);
        j = (j == 15) ? 0 : j + 1;
      end else begin
        step(1'b0, 1'b0, 1'b0);
        rd_chk("gap_off", 1'b0);
        idle_chk("gap_off");
`ifdef HDMI_PIX_UNPACK_LINE_ALIGN_EN
        if (j != 0) begin
          j = 0;
          k = 15;
        end
`endif
      end
    end
    step(1'b0, 1'b0, 1'b0);
    fq.delete();

    // Underflow: empty FIFO at a read point
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0);
      rd_chk("uf", 1'b0);
      pix_chk("uf", -1, i);
      check("uf_pulse", 32'(uf_m), 32'(i == 0));
      check("uf_pulsel", 32'(uf_l), 32'(i == 0));
      check("uf_cnt", 32'(ucnt_m), 32'd1);
    end
    fq.push_back(mk_word(4));
    run_word("uf_next", 4);
    check("uf_cnt2", 32'(ucnt_m), 32'd1);

    // vsync edge during blanking after 7 pixels
    fq.push_back(mk_word(5));
    fq.push_back(mk_word(6));
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0);
      rd_chk("vs", i == 0);
      pix_chk("vs", 5, i);
    end
    step(1'b0, 1'b0, 1'b1);
    rd_chk("vs_blank", 1'b0);
    idle_chk("vs_blank");
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    run_word("vs_new", 6);
    check("vs_fq", 32'(fq.size()), 32'd0);

    // vsync edge coinciding with de mid-word takes priority
    fq.push_back(mk_word(13));
    fq.push_back(mk_word(14));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      pix_chk("vsde", 13, i);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, i == 0);
      rd_chk("vsde_new", i == 0);
      pix_chk("vsde_new", 14, i);
    end
    step(1'b0, 1'b0, 1'b0);
    check("vsde_fq", 32'(fq.size()), 32'd0);

    // Two lines of 20 pixels
    for (int i = 7; i < 11; i++) fq.push_back(mk_word(i));
    k = 7;
    j = 0;
    for (int ln = 0; ln < 2; ln++) begin
      for (int p = 0; p < 20; p++) begin
        step(1'b1, 1'b0, 1'b0);
        rd_chk("line", j == 0);
        pix_chk("line", k, j);
        if (j == 15) begin
          j = 0;
          k++;
        end else begin
          j++;
        end
      end
`ifdef HDMI_PIX_UNPACK_LINE_ALIGN_EN
      if (j != 0) begin
        j = 0;
        k++;
      end
`endif
      for (int b = 0; b < 4; b++) step(1'b0, 1'b0, 1'b0);
    end
    fq.delete();

    // Reset mid-line discards the partial word
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    fq.push_back(mk_word(11));
    fq.push_back(mk_word(12));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      pix_chk("mrst", 11, i);
    end
    check("mrst_ucnt_pre", 32'(ucnt_m), 32'd1);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    rd_chk("mrst", 1'b0);
    idle_chk("mrst");
    check("mrst_ucnt", 32'(ucnt_m), 32'd0);
    rst_n = 1'b1;
    run_word("mrst_new", 12);
    check("mrst_fq", 32'(fq.size()), 32'd0);
    step(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_pix_unpack.md
Name: hdmi_pix_unpack

Overview:
- Parametrised successor to the HDMI read-side width converter.
- Pulls IW-bit words from a first-word-fall-through DMA read FIFO and emits one OW-bit pixel per active video cycle, with timing signals aligned to the pixel data.
- Adds:
  - selectable slice order;
  - FIFO-empty handling with underflow reporting;
  - per-frame realignment of the slice counter on the vsync leading edge.
- Sits between the DDR3 DMA read FIFO and the HDMI TX timing/encoder path, in the hdmi_clk domain.

Parameters:
- IW, 256: FIFO word width; must be an integer multiple of OW.
- OW, 16: pixel width.
- MSB_FIRST, 1: 1 = first pixel taken from bits [IW-1:IW-OW]; 0 = first pixel taken from bits [OW-1:0].
- VS_POL, 1: active level of hdmi_pre_vsync (1 = active-high).
- N (localparam), IW/OW: pixels per word; must be at least 2. Counter width is clog2(N).

Ports:
- hdmi_clk, in, 1: pixel clock.
- rst_n, in, 1: reset, synchronous, active-low.
- hdmi_pre_de, in, 1: active video enable from the timing generator.
- hdmi_pre_hsync, in, 1: hsync from the timing generator.
- hdmi_pre_vsync, in, 1: vsync from the timing generator.
- hdmi_post_de, out, 1: de delayed 1 cycle.
- hdmi_post_hsync, out, 1: hsync delayed 1 cycle.
- hdmi_post_vsync, out, 1: vsync delayed 1 cycle.
- hdmi_pix, out, OW: pixel data, aligned with hdmi_post_de.
- fifo_rd_en, out, 1: FIFO read strobe; combinational.
- fifo_rd_data, in, IW: FIFO head word (FWFT, valid while not empty).
- fifo_empty, in, 1: FIFO empty flag.
- underflow, out, 1: one-cycle pulse when a word was needed but the FIFO was empty.
- underflow_cnt, out, 16: saturating count of underflow events.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - slice counter cnt, shift register sreg, underflow, underflow_cnt;
  - delayed de/hsync/vsync; hdmi_pix therefore reads 0.
- vs_edge = (hdmi_pre_vsync==VS_POL) & (registered previous vsync != VS_POL). The previous-vsync register resets to the inactive level.
- cnt_eff = vs_edge ? 0 : cnt. A vsync edge takes priority over any counter state.
- need = hdmi_pre_de & (cnt_eff==0).
- fifo_rd_en = need & ~fifo_empty. This is combinational, and the word is consumed in the same cycle.
- Each cycle with hdmi_pre_de=1:
  - if need: sreg <= fifo_empty ? 0 : fifo_rd_data;
  - else: sreg shifts by OW toward the output slice (left when MSB_FIRST=1, right when 0), zero-filling.
  - cnt <= (cnt_eff==N-1) ? 0 : cnt_eff+1.
- Cycles with hdmi_pre_de=0: sreg and cnt hold, except that vs_edge forces cnt to 0. A word that is partially consumed at a vsync edge is discarded; it is never re-read.
- Output slice:
  - MSB_FIRST=1: sreg[IW-1:IW-OW];
  - MSB_FIRST=0: sreg[OW-1:0].
- hdmi_pix = hdmi_post_de ? slice : 0.
- Latency: exactly 1 cycle from hdmi_pre_de to the matching hdmi_post_de/hdmi_pix. hsync and vsync get the same delay.
- Underflow:
  - triggered when need & fifo_empty;
  - effect: underflow pulses high for 1 cycle (registered), underflow_cnt increments (saturates at 16'hFFFF), and the word is replaced by zeros;
  - cnt still advances so that pixel alignment is preserved.
- When de is gapped mid-word, pixel order resumes exactly where it stopped.
- rst_n asserted mid-line: all state clears on that edge; the next read occurs at the first de with cnt=0.

Optional Feature:
- Macro: HDMI_PIX_UNPACK_LINE_ALIGN_EN.
- Defined: the falling edge of hdmi_pre_de (registered pre_de=1, current pre_de=0) forces cnt to 0, so every line starts on a fresh FIFO word. Unused slices of the last word are dropped.
- Undefined: cnt carries across lines. The line length must then be a multiple of N, or pixels straddle lines.

Test Plan:
- Continuous de; FIFO words W0=0x000F..0000 through 0x0000..000F (IW=256, OW=16, MSB_FIRST=1) -> fifo_rd_en high on cycles 0, 16, 32; hdmi_pix = W0[255:240] first, then W0 slices in descending order; post_de lags pre_de by 1.
- MSB_FIRST=0, word 0x…0003_0002_0001 -> pixels 0x0001, 0x0002, 0x0003 in order.
- de high 5 cycles, low 3, high 11 -> 16 pixels of one word in order, a single fifo_rd_en, no pixel repeated.
- fifo_empty=1 at a read point -> 16 zero pixels, underflow pulses once, underflow_cnt=1; cnt continues and the next word is read 16 de cycles later.
- vsync leading edge after 7 pixels of a word -> next de reads a new word (fifo_rd_en=1), the 9 leftover slices are never output.
- LINE_ALIGN_EN defined, line length 20 -> each line issues 2 reads; the second line's first pixel is slice 0 of a new word.
